// File: rtl/instruction_register_pkg.sv
// ----------------------------------------------------------------------------
// instruction_register_pkg
// Shared widths and field positions for the instruction register and its
// opcode decoder.
//   OPCODE_W   : opcode field width
//   DATA_W     : data field width
//   INSTR_W    : full instruction word width
//   OPCODE_LSB/OPCODE_MSB, DATA_LSB/DATA_MSB : field bit positions
// ----------------------------------------------------------------------------
package instruction_register_pkg;

   localparam int OPCODE_W   = 4;
   localparam int DATA_W     = 4;
   localparam int INSTR_W    = OPCODE_W + DATA_W;

   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = OPCODE_W - 1;
   localparam int DATA_LSB   = OPCODE_W;
   localparam int DATA_MSB   = INSTR_W - 1;

   localparam int ONEHOT_W   = 1 << OPCODE_W;

endpackage : instruction_register_pkg

// File: rtl/opcode_decoder.sv
// ----------------------------------------------------------------------------
// opcode_decoder
// Purely combinational one-hot decode of an opcode.
// Ports:
//   opcode  [IN_W-1:0]       : opcode to decode
//   onehot  [2**IN_W-1:0]    : bit k set exactly when opcode == k
// ----------------------------------------------------------------------------
module opcode_decoder
   import instruction_register_pkg::*;
#(
   parameter int IN_W = OPCODE_W
) (
   input  logic [IN_W-1:0]        opcode,
   output logic [(1<<IN_W)-1:0]   onehot
);

   always_comb begin
      onehot         = '0;
      onehot[opcode] = 1'b1;
   end

endmodule : opcode_decoder

// File: rtl/instruction_register.sv
// ----------------------------------------------------------------------------
// instruction_register
// Captures an instruction word on every rising clock edge (no enable) and
// presents its opcode/data fields, a one-hot opcode decode, a "captured since
// reset" flag and a "differs from the previous word" flag. All outputs come
// from registers, so nothing on the instruction input reaches an output
// without passing through a clock edge.
//
// Optional feature: define INSTRUCTION_REGISTER_PARITY_EN to add a registered
// even-parity output (XOR of all stored bits).
//
// Ports:
//   clock          : rising-edge clock
//   reset          : synchronous, active-high; wins over a same-edge capture
//   instruction    : word captured each edge while reset is low
//   opcode         : stored bits [OPCODE_W-1:0]
//   data           : stored bits [INSTR_W-1:OPCODE_W]
//   valid          : set on first capture after reset, held until reset
//   opcode_onehot  : decode of stored opcode, all-zero while valid is low
//   changed        : last capture differed from the word it replaced
//   parity         : (PARITY_EN only) XOR of the stored word
// ----------------------------------------------------------------------------
module instruction_register
   import instruction_register_pkg::*;
#(
   parameter int OPCODE_W = instruction_register_pkg::OPCODE_W,
   parameter int DATA_W   = instruction_register_pkg::DATA_W
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [OPCODE_W+DATA_W-1:0]         instruction,
   output logic [OPCODE_W-1:0]                opcode,
   output logic [OPCODE_W+DATA_W-1:OPCODE_W]  data,
   output logic                               valid,
   output logic [(1<<OPCODE_W)-1:0]           opcode_onehot,
   output logic                               changed
`ifdef INSTRUCTION_REGISTER_PARITY_EN
   ,
   output logic                               parity
`endif
);

   localparam int IW = OPCODE_W + DATA_W;

   // instr_q doubles as the "previous word" at each edge: the comparison for
   // changed is made against it before it is overwritten.
   logic [IW-1:0]                instr_q;
   logic                         valid_q;
   logic                         changed_q;
   logic [(1<<OPCODE_W)-1:0]     decode_raw;

   always_ff @(posedge clock) begin
      if (reset) begin
         instr_q   <= '0;
         valid_q   <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         instr_q   <= instruction;
         valid_q   <= 1'b1;
         // First capture after reset has no predecessor to differ from.
         changed_q <= valid_q && (instruction != instr_q);
      end
   end

`ifdef INSTRUCTION_REGISTER_PARITY_EN
   logic parity_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= ^instruction;
      end
   end

   assign parity = parity_q;
`endif

   opcode_decoder #(
      .IN_W   (OPCODE_W)
   ) u_opcode_decoder (
      .opcode (instr_q[OPCODE_W-1:0]),
      .onehot (decode_raw)
   );

   assign opcode        = instr_q[OPCODE_W-1:0];
   assign data          = instr_q[IW-1:OPCODE_W];
   assign valid         = valid_q;
   assign changed       = changed_q;
   // The decoder sees opcode 0 after reset; suppress it until a real capture.
   assign opcode_onehot = valid_q ? decode_raw : '0;

endmodule : instruction_register

// File: tb/tb_instruction_register.sv
// ----------------------------------------------------------------------------
// tb_instruction_register
// Random and directed stimulus for instruction_register, checked against a
// history-of-captured-words model on every cycle, plus literal expectations
// for the key scenarios.
// ----------------------------------------------------------------------------
module tb_instruction_register;

   logic        clock;
   logic        reset;
   logic [7:0]  instruction;
   logic [3:0]  opcode;
   logic [7:4]  data;
   logic        valid;
   logic [15:0] opcode_onehot;
   logic        changed;
`ifdef INSTRUCTION_REGISTER_PARITY_EN
   logic        parity;
`endif

   int total = 0;
   int bad   = 0;

   // Model: words captured since the last reset (only the newest two kept).
   logic [7:0] hist[$];
   bit         model_live = 0;

   instruction_register dut (
      .clock         (clock),
      .reset         (reset),
      .instruction   (instruction),
      .opcode        (opcode),
      .data          (data),
      .valid         (valid),
      .opcode_onehot (opcode_onehot),
      .changed       (changed)
`ifdef INSTRUCTION_REGISTER_PARITY_EN
      ,
      .parity        (parity)
`endif
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model + compare process ----------------
   task automatic compare_model(input string tag);
      logic [7:0]  w;
      logic        e_valid;
      logic        e_changed;
      logic [15:0] e_onehot;
      e_valid   = (hist.size() > 0);
      w         = e_valid ? hist[hist.size()-1] : 8'h00;
      e_changed = (hist.size() >= 2) && (hist[hist.size()-1] != hist[hist.size()-2]);
      e_onehot  = e_valid ? (16'h1 << w[3:0]) : 16'h0;
      check({tag, ".opcode"},  32'(opcode),        32'(w[3:0]));
      check({tag, ".data"},    32'(data),          32'(w[7:4]));
      check({tag, ".valid"},   32'(valid),         32'(e_valid));
      check({tag, ".changed"}, 32'(changed),       32'(e_changed));
      check({tag, ".onehot"},  32'(opcode_onehot), 32'(e_onehot));
`ifdef INSTRUCTION_REGISTER_PARITY_EN
      check({tag, ".parity"},  32'(parity),        32'(^w));
`endif
   endtask

   always @(posedge clock) begin
      if (reset) begin
         hist.delete();
         model_live = 1;
      end else if (model_live) begin
         hist.push_back(instruction);
         if (hist.size() > 2) void'(hist.pop_front());
      end
      #1;
      if (model_live) compare_model("post_edge");
      // Late in the cycle, after any mid-cycle input toggling.
      #7;
      if (model_live) compare_model("late_cycle");
   end

   // ---------------- driver ----------------
   // Called at edge+3: applies inputs, optionally toggles to a second value
   // mid-cycle, then returns at the following edge+2 (after the checker's
   // post-edge sample) so literal checks can be made.
   task automatic step(input logic r, input logic [7:0] i);
      reset       = r;
      instruction = i;
      @(posedge clock);
      #2;
   endtask

   task automatic step_toggle(input logic r, input logic [7:0] i0, input logic [7:0] i1);
      reset       = r;
      instruction = i0;
      #3;
      instruction = i1;
      @(posedge clock);
      #2;
   endtask

   initial begin
      logic [7:0] a;
      logic [7:0] b;
      reset       = 1'b1;
      instruction = 8'h4F;
      @(posedge clock);
      #3;

      // Reset with 4F on the input: everything cleared.
      step(1'b1, 8'h4F);
      check("reset.opcode",  32'(opcode),        32'h0);
      check("reset.data",    32'(data),          32'h0);
      check("reset.valid",   32'(valid),         32'h0);
      check("reset.changed", 32'(changed),       32'h0);
      check("reset.onehot",  32'(opcode_onehot), 32'h0);
      #1;

      // Capture 4F.
      step(1'b0, 8'h4F);
      check("cap.opcode",  32'(opcode),        32'hF);
      check("cap.data",    32'(data),          32'h4);
      check("cap.valid",   32'(valid),         32'h1);
      check("cap.onehot",  32'(opcode_onehot), 32'h8000);
      check("cap.changed", 32'(changed),       32'h0);
`ifdef INSTRUCTION_REGISTER_PARITY_EN
      check("par.4F", 32'(parity), 32'h1);
`endif
      #1;

      // Hold 4F a second edge, then 4E.
      step(1'b0, 8'h4F);
      check("hold.changed", 32'(changed), 32'h0);
      #1;
      step(1'b0, 8'h4E);
      check("chg.changed", 32'(changed), 32'h1);
      check("chg.opcode",  32'(opcode),  32'hE);
`ifdef INSTRUCTION_REGISTER_PARITY_EN
      check("par.4E", 32'(parity), 32'h0);
`endif
      #1;

      // Reset and A5 at the same edge: reset wins.
      step(1'b1, 8'hA5);
      check("prio.opcode", 32'(opcode), 32'h0);
      check("prio.data",   32'(data),   32'h0);
      check("prio.valid",  32'(valid),  32'h0);
      #1;
      step(1'b0, 8'hA5);
      check("resume.opcode",  32'(opcode),  32'h5);
      check("resume.data",    32'(data),    32'hA);
      check("resume.changed", 32'(changed), 32'h0);
      #1;

      // Mid-cycle toggle: only the value present at the edge is taken.
      step_toggle(1'b0, 8'h12, 8'h37);
      check("toggle.opcode", 32'(opcode), 32'h7);
      check("toggle.data",   32'(data),   32'h3);
      #1;

      // Randomized run against the model.
      for (int n = 0; n < 300; n++) begin
         a = 8'($urandom_range(0, 255));
         // Bias toward repeats so changed=0 is exercised often.
         if ($urandom_range(0, 3) == 0 && hist.size() > 0) a = hist[hist.size()-1];
         b = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1)
            step_toggle(($urandom_range(0, 15) == 0), b, a);
         else
            step(($urandom_range(0, 15) == 0), a);
         #1;
      end

      reset = 1'b0;
      @(posedge clock);
      #9;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_instruction_register

// File: doc/instruction_register.md
INSTRUCTION_REGISTER -- requirements
Module: instruction_register

Interface
REQ-001 SHALL have parameter OPCODE_W, default 4, meaning opcode field width.
REQ-002 SHALL have parameter DATA_W, default 4, meaning data field width; instruction width = OPCODE_W+DATA_W (8).
REQ-003 SHALL have port clock  input  1  single clock for all state; rising edge active.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port instruction  input  8  instruction word to capture.
REQ-006 SHALL have port opcode  output  4  stored instruction bits [3:0].
REQ-007 SHALL have port data  output  4  stored instruction bits [7:4], declared with range [7:4].
REQ-008 SHALL have port valid  output  1  high once an instruction has been captured since reset.
REQ-009 SHALL have port opcode_onehot  output  16  one-hot decode of the stored opcode.
REQ-010 SHALL have port changed  output  1  stored instruction differs from the previously stored one.

Function
REQ-011 SHALL capture instruction into an 8-bit register on every rising clock edge while reset is low, with no enable.
REQ-012 SHALL drive opcode and data from the register, updating one edge after instruction is applied, with no combinational path from input to output.
REQ-013 SHALL set valid to 1 on the first capture edge after reset and hold it at 1 until the next reset.
REQ-014 SHALL drive opcode_onehot[k] = 1 exactly when the stored opcode = k; all other bits 0.
REQ-015 SHALL register changed = 1 when the newly captured word != the word held before that edge; 0 on the first capture after reset.
REQ-016 SHALL keep all outputs constant between rising edges, including when instruction toggles mid-cycle.
REQ-017 SHALL let reset take priority when reset and a new instruction arrive at the same edge.

Reset
REQ-018 SHALL, on a rising edge with reset high, clear the stored word, opcode, data, valid and changed to 0, and clear the previous-word register to 0.
REQ-019 SHALL drive opcode_onehot = 16'h0001 during and after reset (decode of opcode 0), gated to 16'h0000 while valid = 0.
REQ-020 SHALL, on reset asserted mid-operation, discard the pending instruction at that edge; capture resumes on the first edge with reset low.

Configuration
REQ-021 SHALL, when macro INSTRUCTION_REGISTER_PARITY_EN is defined, add output parity (1 bit) = XOR of all 8 stored bits, registered alongside opcode and data, reset to 0.
REQ-022 SHALL, when INSTRUCTION_REGISTER_PARITY_EN is undefined, omit the parity port and logic; all other behaviour is unchanged.

Structure
REQ-023 SHALL place OPCODE_W, DATA_W, INSTR_W and the opcode/data field bit positions in shared package instruction_register_pkg.
REQ-024 SHALL implement the one-hot decode in sub-module opcode_decoder (4-bit input, 16-bit one-hot output, purely combinational).

Verification
REQ-025 SHALL check capture: reset low, instruction = 8'h4F -> after the next edge opcode = 4'hF, data = 4'h4, valid = 1, opcode_onehot = 16'h8000.
REQ-026 SHALL check reset: reset high for 1 edge while instruction = 8'h4F -> opcode = 0, data = 0, valid = 0, changed = 0, opcode_onehot = 0.
REQ-027 SHALL check changed: hold 8'h4F for 2 edges then apply 8'h4E -> changed = 0 after the 2nd edge, 1 after the 3rd, opcode = 4'hE.
REQ-028 SHALL check priority: reset and instruction 8'hA5 applied at the same edge -> outputs 0; next edge with reset low -> opcode = 4'h5, data = 4'hA.
REQ-029 SHALL check stability: toggle instruction between edges -> outputs change only at rising edges.
REQ-030 SHALL check parity with INSTRUCTION_REGISTER_PARITY_EN defined: 8'h4F -> parity = 1; 8'h4E -> parity = 0.
